ds_timer_mc: RTL and testbench

Multi-channel dump/sustain delay timer for the NMR pulse-sequence controller. On a rising edge of `state_start`, each enabled channel counts a programmable number of 10 kHz ticks and then issues a one-cycle `start` strobe, either once or periodically. It supersedes the single-channel, fixed 4-bit dump/sustain timer. All logic runs on `clk_sys`; the 10 kHz timebase arrives as an enable strobe rather than a second clock.

---
 rtl/ds_timer_pkg.sv | 14 +
 rtl/ds_timer_ch.sv | 85 ++++++++
 rtl/ds_timer_mc.sv | 58 +++++
 tb/tb_ds_timer_mc.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_timer_pkg.sv
// Shared types for the multi-channel dump/sustain delay timer.
// Channel FSM encoding and per-channel mode constants.
package ds_timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      FIRE  = 2'd2
   } ds_state_t;

   localparam logic DS_ONESHOT  = 1'b0;
   localparam logic DS_PERIODIC = 1'b1;

endpackage

// File: rtl/ds_timer_ch.sv
// One delay channel: arms on trig, counts d ticks, then strobes start for one cycle.
// Strobe lands the cycle after the d-th tick (d=0: cycle after trig); no backpressure.
module ds_timer_ch
   import ds_timer_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk_sys,
   input  logic          rst,
   input  logic          tick,
   input  logic          trig,
   input  logic          en,
   input  logic          mode,
   input  logic [DW-1:0] data,
   output logic          start,
   output logic          busy
);

   localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

   ds_state_t     state_q, state_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] dly_q, dly_d;
   logic          arm;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dly_d   = dly_q;
      // A trigger while counting restarts the channel and outranks a coincident tick.
      arm     = trig && en && (state_q == IDLE || state_q == COUNT);

      if (arm) begin
         dly_d = data;
         if (data == '0) begin
            state_d = FIRE;
         end else begin
            cnt_d   = data;
            state_d = COUNT;
         end
      end else begin
         unique case (state_q)
            IDLE: state_d = IDLE;
            COUNT: begin
               if (!en) begin
                  state_d = IDLE;
               end else if (tick) begin
                  if (cnt_q <= ONE) state_d = FIRE;
                  else              cnt_d   = cnt_q - ONE;
               end
            end
            FIRE: begin
               if (mode == DS_PERIODIC && en) begin
                  // A tick seen here already belongs to the next period.
                  if (dly_q == '0 || (tick && dly_q == ONE)) begin
                     state_d = FIRE;
                  end else begin
                     state_d = COUNT;
                     cnt_d   = tick ? dly_q - ONE : dly_q;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dly_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dly_q   <= dly_d;
      end
   end

   assign start = (state_q == FIRE);
   assign busy  = (state_q != IDLE);

endmodule

// File: rtl/ds_timer_mc.sv
// Multi-channel dump/sustain timer: shared state_start edge detect feeding NCH channels.
// Strobe latency d ticks after the trigger edge (1 cycle when d=0); no backpressure.
module ds_timer_mc #(
   parameter int NCH = 2,
   parameter int DW  = 8
) (
   input  logic              clk_sys,
   input  logic              rst,
   input  logic              tick_10k,
   input  logic              state_start,
   input  logic [NCH-1:0]    dump_sustain,
   input  logic [NCH-1:0]    mode,
   input  logic [NCH*DW-1:0] dump_sustain_data,
   output logic [NCH-1:0]    start,
   output logic [NCH-1:0]    busy,
   output logic              start_any
);

   logic ss_q, ss_d;
   logic low_seen_q, low_seen_d;
   logic trig;

   // low_seen keeps a level already high at reset release from looking like an edge.
   always_comb begin
      ss_d       = state_start;
      low_seen_d = low_seen_q | ~state_start;
      trig       = state_start & ~ss_q & low_seen_q;
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         ss_q       <= 1'b0;
         low_seen_q <= 1'b0;
      end else begin
         ss_q       <= ss_d;
         low_seen_q <= low_seen_d;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      ds_timer_ch #(
         .DW (DW)
      ) u_ch (
         .clk_sys (clk_sys),
         .rst     (rst),
         .tick    (tick_10k),
         .trig    (trig),
         .en      (dump_sustain[i]),
         .mode    (mode[i]),
         .data    (dump_sustain_data[i*DW +: DW]),
         .start   (start[i]),
         .busy    (busy[i])
      );
   end

   assign start_any = |start;

endmodule

// File: tb/tb_ds_timer_mc.sv
// Bench for ds_timer_mc: directed phases plus random traffic, scored against a tick-counting model.
module tb_ds_timer_mc;

   localparam int NCH = 2;
   localparam int DW  = 8;

   logic              clk_sys = 1'b0;
   logic              rst;
   logic              tick_10k;
   logic              state_start;
   logic [NCH-1:0]    dump_sustain;
   logic [NCH-1:0]    mode;
   logic [NCH*DW-1:0] dump_sustain_data;
   logic [NCH-1:0]    start;
   logic [NCH-1:0]    busy;
   logic              start_any;

   always #5 clk_sys = ~clk_sys;

   ds_timer_mc #(.NCH(NCH), .DW(DW)) dut (
      .clk_sys           (clk_sys),
      .rst               (rst),
      .tick_10k          (tick_10k),
      .state_start       (state_start),
      .dump_sustain      (dump_sustain),
      .mode              (mode),
      .dump_sustain_data (dump_sustain_data),
      .start             (start),
      .busy              (busy),
      .start_any         (start_any)
   );

   int cyc    = 0;
   int n_chk  = 0;
   int n_pass = 0;

   // Expected strobe cycles per channel, pushed by the model, popped by the monitor.
   int exp_q [NCH][$];

   // Model: a channel fires whenever the ticks seen since arming reach a multiple of d.
   bit m_act  [NCH];
   bit m_fire [NCH];
   int m_d    [NCH];
   int m_tk   [NCH];
   bit m_prev = 1'b1;

   int tick_period = 0;
   int tph         = 0;
   bit tick_rand   = 1'b0;
   bit tick_force  = 1'b0;

   task automatic chk(input bit ok, input string nm, input int act, input int exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
   endtask

   initial begin : model
      bit trig;
      bit was_fire;
      bit en;
      forever begin
         @(posedge clk_sys);
         cyc++;
         if (rst) begin
            for (int i = 0; i < NCH; i++) begin
               m_act[i]  = 1'b0;
               m_fire[i] = 1'b0;
            end
            m_prev = 1'b1;
         end else begin
            trig   = state_start && !m_prev;
            m_prev = state_start;
            for (int i = 0; i < NCH; i++) begin
               was_fire  = m_fire[i];
               en        = dump_sustain[i];
               m_fire[i] = 1'b0;
               if (was_fire) begin
                  if (mode[i] && en) begin
                     if (tick_10k) m_tk[i]++;
                     m_fire[i] = (m_d[i] == 0) || (tick_10k && (m_tk[i] % m_d[i] == 0));
                  end else begin
                     m_act[i] = 1'b0;
                  end
               end else if (m_act[i] && !en) begin
                  m_act[i] = 1'b0;
               end else if (trig && en) begin
                  m_d[i]    = int'(dump_sustain_data[i*DW +: DW]);
                  m_tk[i]   = 0;
                  m_act[i]  = 1'b1;
                  m_fire[i] = (m_d[i] == 0);
               end else if (m_act[i] && tick_10k) begin
                  m_tk[i]++;
                  m_fire[i] = (m_tk[i] % m_d[i] == 0);
               end
               if (m_fire[i]) exp_q[i].push_back(cyc);
            end
         end
      end
   end

   initial begin : monitor
      bit e;
      bit any;
      forever begin
         @(negedge clk_sys);
         if (cyc > 0) begin
            any = 1'b0;
            for (int i = 0; i < NCH; i++) begin
               e = (exp_q[i].size() > 0) && (exp_q[i][0] == cyc);
               if (e) void'(exp_q[i].pop_front());
               any = any | e;
               chk(start[i] === e, $sformatf("start[%0d]", i), int'(start[i]), int'(e));
               chk(busy[i] === m_act[i], $sformatf("busy[%0d]", i), int'(busy[i]), int'(m_act[i]));
            end
            chk(start_any === any, "start_any", int'(start_any), int'(any));
         end
      end
   end

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         if (tick_force)           tick_10k = 1'b1;
         else if (tick_period > 0) tick_10k = (tph == 0);
         else if (tick_rand)       tick_10k = ($urandom_range(0, 3) == 0);
         else                      tick_10k = 1'b0;
         if (tick_period > 0) tph = (tph + 1) % tick_period;
         tick_force = 1'b0;
         @(negedge clk_sys);
      end
   endtask

   task automatic set_ch(input int ch, input int d);
      dump_sustain_data[ch*DW +: DW] = DW'(d);
   endtask

   task automatic pulse_start();
      state_start = 1'b1;
      step(2);
      state_start = 1'b0;
      step(1);
   endtask

   initial begin : stim
      rst               = 1'b1;
      tick_10k          = 1'b0;
      state_start       = 1'b0;
      dump_sustain      = '0;
      mode              = '0;
      dump_sustain_data = '0;
      step(4);
      rst = 1'b0;
      step(3);

      // One-shot d=3 on ch0, ch1 disabled.
      tick_period = 10;
      dump_sustain = 2'b01;
      set_ch(0, 3);
      set_ch(1, 7);
      pulse_start();
      step(50);

      // d=0: strobe right after the trigger edge.
      set_ch(0, 0);
      pulse_start();
      step(5);

      // Periodic ch1 d=2, then disable it.
      dump_sustain = 2'b10;
      mode         = 2'b10;
      set_ch(1, 2);
      pulse_start();
      step(70);
      dump_sustain = 2'b00;
      step(30);

      // Abort after 3 ticks, then retrigger mid-count.
      mode         = 2'b00;
      dump_sustain = 2'b01;
      set_ch(0, 5);
      pulse_start();
      step(30);
      dump_sustain = 2'b00;
      step(20);
      dump_sustain = 2'b01;
      pulse_start();
      step(28);
      pulse_start();
      step(70);

      // Tick coincident with the arming edge is ignored.
      tick_period = 0;
      set_ch(0, 1);
      step(2);
      state_start = 1'b1;
      tick_force  = 1'b1;
      step(1);
      state_start = 1'b0;
      step(4);
      tick_force = 1'b1;
      step(1);
      step(4);

      // Reset while both channels are counting.
      dump_sustain = 2'b11;
      mode         = 2'b10;
      set_ch(0, 5);
      set_ch(1, 3);
      pulse_start();
      tick_force = 1'b1;
      step(1);
      step(3);
      tick_force = 1'b1;
      step(1);
      step(2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(8);

      // state_start held high across reset release, then a fresh edge.
      mode = 2'b00;
      set_ch(0, 2);
      set_ch(1, 1);
      state_start = 1'b1;
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      tick_period = 5;
      tph = 0;
      step(20);
      state_start = 1'b0;
      step(2);
      state_start = 1'b1;
      step(30);
      state_start = 1'b0;
      step(5);

      // Random traffic.
      tick_period = 0;
      tick_rand   = 1'b1;
      for (int n = 0; n < 2500; n++) begin
         if ($urandom_range(0, 9) == 0) state_start = ~state_start;
         if ($urandom_range(0, 39) == 0)
            dump_sustain = ($urandom_range(0, 3) == 0) ? NCH'($urandom_range(0, 3)) : 2'b11;
         if ($urandom_range(0, 29) == 0) mode = NCH'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) begin
            for (int i = 0; i < NCH; i++) set_ch(i, $urandom_range(0, 4));
         end
         rst = ($urandom_range(0, 499) == 0);
         step(1);
      end
      rst          = 1'b0;
      dump_sustain = '0;
      step(5);

      for (int i = 0; i < NCH; i++)
         chk(exp_q[i].size() == 0, $sformatf("pending_strobes[%0d]", i), exp_q[i].size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
